maxpool_rowbuf: RTL and testbench
=================================

MAXPOOL_ROWBUF -- requirements
Module: maxpool_rowbuf

Interface
REQ-001 SHALL have parameter M, default 16, data width in bits.
REQ-002 SHALL have parameter W, default 14, number of horizontally pooled samples per row.
REQ-003 SHALL have parameter H, default 28, number of input rows per frame; H is even and at least 2.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port Rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port clear, input, 1 bit: synchronous frame restart, sampled on clk.
REQ-007 SHALL have port din, input, M bits: horizontally pooled sample from the upstream 2:1 line max stage.
REQ-008 SHALL have port valid_in, input, 1 bit: din is valid this cycle; no backpressure.
REQ-009 SHALL have port result, output reg, M bits: 2x2 max-pooled sample.
REQ-010 SHALL have port valid_out, output reg, 1 bit: result is valid this cycle.
REQ-011 SHALL have port frame_done, output reg, 1 bit: one-cycle pulse coincident with the last result of a frame.

Function
REQ-012 SHALL keep a column counter col (0..W-1) that advances on each valid_in and wraps W-1 -> 0.
REQ-013 SHALL keep a row counter row (0..H-1) that advances when col wraps, and SHALL wrap H-1 -> 0.
REQ-014 SHALL run a two-state machine: FILL (row even) and COMPARE (row odd).
- Reset state: FILL.
- FILL -> COMPARE when col wraps.
- COMPARE -> FILL when col wraps.
REQ-015 SHALL contain a W-entry, M-bit line buffer.
REQ-016 SHALL, in FILL with valid_in=1, write din to buffer[col] and hold valid_out at 0.
REQ-017 SHALL, in COMPARE with valid_in=1, register result = max(buffer[col], din) and valid_out=1 on the next rising edge; latency is exactly 1 cycle.
REQ-018 SHALL compare as unsigned M-bit values; on equal values, result = din.
REQ-019 SHALL drive result=0 and valid_out=0 in every cycle that produces no output.
REQ-020 SHALL assert frame_done together with valid_out for the output where row=H-1 and col=W-1, and hold it at 0 otherwise.
REQ-021 SHALL ignore din and hold all counters and state when valid_in=0, including gaps inside a row.
REQ-022 SHALL, when clear=1, next cycle set col=0, row=0, state FILL, result=0, valid_out=0, frame_done=0; clear overrides a simultaneous valid_in and that sample is dropped.
REQ-023 SHALL NOT reset or clear the line buffer; FILL always overwrites every entry before COMPARE reads it.
REQ-024 SHALL keep the fill rate identical to the input rate: one write or one output per accepted sample, with no stall cycles.

Reset
REQ-025 SHALL, while Rst_n=0, force result=0, valid_out=0, frame_done=0, col=0, row=0, state FILL, independent of clk.
REQ-026 SHALL treat reset assertion mid-row or mid-frame as a full restart; the first valid_in after release is row 0, col 0.

Verification (W=4, H=4, M=16)
REQ-027 Rows 0 and 1 are streamed back-to-back:
- Row 0 = {3,9,2,7}, row 1 = {5,1,2,8}.
- Required: valid_out pulses with results 5,9,2,8, each 1 cycle after the matching row-1 valid_in.
- Required: no valid_out during row 0.
REQ-028 Unsigned compare check:
- Row 0 = {16'h8000,…}, row 1 = {16'h0001,…}.
- Required: first result is 16'h8000.
REQ-029 Full 4-row frame:
- Required: exactly 8 valid_out pulses.
- Required: frame_done is high only with the 8th pulse.
- Required: the next frame starts in FILL.
REQ-030 Row 1 is sent with valid_in gaps of 0-3 idle cycles:
- Required: results are identical to the gap-free case.
- Required: valid_out stays 0 during gaps.
REQ-031 clear is asserted mid-COMPARE (row 1, col 2) with valid_in=1:
- Required: that sample is dropped and no valid_out follows.
- Required: the next row is treated as row 0 (FILL).
REQ-032 Rst_n is pulled low asynchronously mid-cycle during row 1:
- Required: outputs go to 0 immediately.
- Required: after release, a fresh 2-row stimulus yields correct results.

Source files
------------

// File: rtl/maxpool_rowbuf.sv
`default_nettype none
// ---------------------------------------------------------------------------
// maxpool_rowbuf: second (vertical) stage of 2x2 max pooling via a line buffer
// Revision: 1.0
// ---------------------------------------------------------------------------
module maxpool_rowbuf #(
  parameter int M = 16,
  parameter int W = 14,
  parameter int H = 28
) (
  input  logic         clk,
  input  logic         Rst_n,
  input  logic         clear,
  input  logic [M-1:0] din,
  input  logic         valid_in,
  output logic [M-1:0] result,
  output logic         valid_out,
  output logic         frame_done
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int RW = (H > 1) ? $clog2(H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(H - 1);

  typedef enum logic [0:0] {
    FILL    = 1'b0,
    COMPARE = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  col_q, col_d;
  logic [RW-1:0]  row_q, row_d;
  logic [M-1:0]   result_q, result_d;
  logic           valid_out_q, valid_out_d;
  logic           frame_done_q, frame_done_d;

  logic [M-1:0]   line_buf [W];
  logic [M-1:0]   buf_rd;
  logic           col_wrap;
  logic           buf_we;

  assign buf_rd   = line_buf[col_q];
  assign col_wrap = (col_q == COL_LAST);
  assign buf_we   = valid_in && !clear && (state_q == FILL);

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    result_d     = '0;
    valid_out_d  = 1'b0;
    frame_done_d = 1'b0;
    if (clear) begin
      state_d = FILL;
      col_d   = '0;
      row_d   = '0;
    end else if (valid_in) begin
      col_d = col_wrap ? '0 : col_q + 1'b1;
      if (col_wrap) begin
        row_d   = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
        state_d = (state_q == FILL) ? COMPARE : FILL;
      end
      if (state_q == COMPARE) begin
        // Ties resolve to the incoming sample.
        result_d     = (buf_rd > din) ? buf_rd : din;
        valid_out_d  = 1'b1;
        frame_done_d = col_wrap && (row_q == ROW_LAST);
      end
    end
  end

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q      <= FILL;
      col_q        <= '0;
      row_q        <= '0;
      result_q     <= '0;
      valid_out_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      result_q     <= result_d;
      valid_out_q  <= valid_out_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Storage is deliberately unreset: every entry is rewritten in FILL before use.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      line_buf[col_q] <= din;
    end
  end

  assign result     = result_q;
  assign valid_out  = valid_out_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_maxpool_rowbuf.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_maxpool_rowbuf: randomized and directed checks against a frame-level model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_maxpool_rowbuf;
  localparam int M = 16;
  localparam int W = 4;
  localparam int H = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clear = 1'b0;
  logic         valid_in = 1'b0;
  logic [M-1:0] din = '0;
  logic [M-1:0] result;
  logic         valid_out;
  logic         frame_done;

  maxpool_rowbuf #(.M(M), .W(W), .H(H)) dut (
    .clk        (clk),
    .Rst_n      (rst_n),
    .clear      (clear),
    .din        (din),
    .valid_in   (valid_in),
    .result     (result),
    .valid_out  (valid_out),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: the accepted samples of the current frame, indexed by arrival order.
  logic [M-1:0] frame_mem [W*H];
  int           k = 0;
  logic         exp_v = 1'b0;
  logic         exp_d = 1'b0;
  logic [M-1:0] exp_r = '0;

  logic [M-1:0] got [$];
  int           done_cnt = 0;
  int           done_at = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_step();
    int r;
    exp_v = 1'b0;
    exp_r = '0;
    exp_d = 1'b0;
    if (!rst_n || clear) begin
      k = 0;
    end else if (valid_in) begin
      r = k / W;
      frame_mem[k] = din;
      if (r % 2 == 1) begin
        exp_v = 1'b1;
        exp_r = (frame_mem[k-W] > din) ? frame_mem[k-W] : din;
        exp_d = (k == W*H - 1);
      end
      k = (k + 1) % (W*H);
    end
  endtask

  task automatic compare();
    chk("valid_out", {31'd0, valid_out}, {31'd0, exp_v});
    chk("result", {16'd0, result}, {16'd0, exp_r});
    chk("frame_done", {31'd0, frame_done}, {31'd0, exp_d});
    if (valid_out) begin
      got.push_back(result);
      if (frame_done) begin
        done_cnt++;
        done_at = got.size();
      end
    end
  endtask

  // One clock: drive at negedge, model at posedge, compare at next negedge.
  task automatic cyc(input logic v, input logic [M-1:0] d, input logic clr);
    valid_in = v;
    din      = d;
    clear    = clr;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
    valid_in = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic send_row(input logic [M-1:0] a [W], input int maxgap);
    for (int c = 0; c < W; c++) begin
      repeat ($urandom_range(0, maxgap)) cyc(1'b0, M'($urandom), 1'b0);
      cyc(1'b1, a[c], 1'b0);
    end
  endtask

  task automatic rand_row(output logic [M-1:0] a [W]);
    for (int c = 0; c < W; c++) a[c] = M'($urandom);
  endtask

  logic [M-1:0] ra [W];
  logic [M-1:0] rb [W];
  logic [M-1:0] want [W];

  initial begin
    // Reset state
    @(negedge clk);
    chk("reset_valid_out", {31'd0, valid_out}, 32'd0);
    chk("reset_result", {16'd0, result}, 32'd0);
    chk("reset_frame_done", {31'd0, frame_done}, 32'd0);
    cyc(1'b1, 16'h1234, 1'b0);
    rst_n = 1'b1;

    // Two back-to-back rows with known values
    got.delete();
    ra = '{16'd3, 16'd9, 16'd2, 16'd7};
    rb = '{16'd5, 16'd1, 16'd2, 16'd8};
    send_row(ra, 0);
    chk("row0_no_pulses", got.size(), 32'd0);
    send_row(rb, 0);
    want = '{16'd5, 16'd9, 16'd2, 16'd8};
    chk("row1_pulses", got.size(), 32'd4);
    for (int c = 0; c < W; c++)
      if (c < got.size()) chk("row1_lit", {16'd0, got[c]}, {16'd0, want[c]});

    // Finish the frame
    done_cnt = 0;
    rand_row(ra); send_row(ra, 0);
    rand_row(rb); send_row(rb, 0);
    chk("frame_pulses", got.size(), 32'd8);
    chk("frame_done_cnt", done_cnt, 32'd1);
    chk("frame_done_at", done_at, 32'd8);

    // Next frame starts in FILL; unsigned compare
    got.delete();
    ra = '{16'h8000, 16'h0010, 16'h7fff, 16'h0000};
    rb = '{16'h0001, 16'h0010, 16'h8000, 16'hffff};
    send_row(ra, 0);
    chk("newframe_fill", got.size(), 32'd0);
    send_row(rb, 0);
    if (got.size() > 0) chk("unsigned_first", {16'd0, got[0]}, 32'h8000);
    else chk("unsigned_first_missing", got.size(), 32'd4);

    // Rows 2/3 with gaps in the compare row
    got.delete();
    rand_row(ra); rand_row(rb);
    send_row(ra, 0);
    send_row(rb, 3);
    for (int c = 0; c < W; c++) want[c] = (ra[c] > rb[c]) ? ra[c] : rb[c];
    chk("gap_pulses", got.size(), 32'd4);
    for (int c = 0; c < W; c++)
      if (c < got.size()) chk("gap_lit", {16'd0, got[c]}, {16'd0, want[c]});

    // Clear mid-COMPARE at row 1, col 2 with valid_in high
    rand_row(ra); send_row(ra, 0);
    cyc(1'b1, 16'h0100, 1'b0);
    cyc(1'b1, 16'h0200, 1'b0);
    got.delete();
    cyc(1'b1, 16'hffff, 1'b1);
    cyc(1'b0, 16'h0000, 1'b0);
    chk("clear_dropped", got.size(), 32'd0);
    rand_row(ra); send_row(ra, 1);
    chk("clear_then_fill", got.size(), 32'd0);
    rand_row(rb); send_row(rb, 1);
    chk("clear_then_compare", got.size(), 32'd4);

    // Asynchronous reset mid-cycle during row 1
    rand_row(ra); send_row(ra, 0);
    rand_row(ra); send_row(ra, 0);
    rand_row(ra); send_row(ra, 0);
    cyc(1'b1, 16'h0055, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid_out", {31'd0, valid_out}, 32'd0);
    chk("async_result", {16'd0, result}, 32'd0);
    chk("async_frame_done", {31'd0, frame_done}, 32'd0);
    k = 0; exp_v = 1'b0; exp_r = '0; exp_d = 1'b0;
    @(negedge clk);
    cyc(1'b1, 16'h7777, 1'b0);
    rst_n = 1'b1;
    got.delete();
    ra = '{16'd10, 16'd20, 16'd30, 16'd40};
    rb = '{16'd15, 16'd15, 16'd35, 16'd35};
    send_row(ra, 2);
    send_row(rb, 2);
    want = '{16'd15, 16'd20, 16'd35, 16'd40};
    chk("post_reset_pulses", got.size(), 32'd4);
    for (int c = 0; c < W; c++)
      if (c < got.size()) chk("post_reset_lit", {16'd0, got[c]}, {16'd0, want[c]});

    // Randomized traffic with gaps and occasional clear
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 3) != 0, M'($urandom), $urandom_range(0, 59) == 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
